// File: rtl/cnn_mac_pkg.sv
// Shared definitions for the CNN multiply-accumulate pipeline.
//  - Representation selector constants.
//  - FSM state encoding for the window accumulator.
//  - Saturation bound helpers used to build the result clamp limits.
package cnn_mac_pkg;

  localparam bit REP_SIGNED   = 1'b1;
  localparam bit REP_UNSIGNED = 1'b0;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } state_e;

  // Largest value representable in w bits (w <= 63).
  function automatic logic signed [63:0] sat_max(input int unsigned w, input bit sgn);
    if (sgn) begin
      return (64'sd1 <<< (w - 1)) - 64'sd1;
    end
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

  // Smallest value representable in w bits (w <= 63).
  function automatic logic signed [63:0] sat_min(input int unsigned w, input bit sgn);
    if (sgn) begin
      return -(64'sd1 <<< (w - 1));
    end
    return 64'sd0;
  endfunction

endpackage

// File: rtl/cnn_mult_pipe.sv
// Pipelined multiplier with sideband.
//  Ports:
//   clock, aclr_n, clken      : clock, async active-low reset, clock enable
//   in_valid/in_first/in_last : beat qualifiers, delayed alongside the product
//   dataa, datab              : operands (signed or unsigned per IS_SIGNED)
//   sum                       : bias, delayed alongside the product
//   out_*                     : the same beat PIPELINE enabled cycles later
module cnn_mult_pipe #(
  parameter int unsigned WIDTHA    = 8,
  parameter int unsigned WIDTHB    = 8,
  parameter int unsigned WIDTHS    = 16,
  parameter int unsigned PIPELINE  = 2,
  parameter bit          IS_SIGNED = 1'b1
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic                     clken,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [WIDTHA-1:0]        dataa,
  input  logic [WIDTHB-1:0]        datab,
  input  logic [WIDTHS-1:0]        sum,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic [WIDTHS-1:0]        out_bias,
  output logic [WIDTHA+WIDTHB-1:0] out_prod
);

  localparam int unsigned PW = WIDTHA + WIDTHB;

  logic [PW-1:0] prod_in;

  // The operands are widened to the full product width first, so the low PW bits of the
  // PW x PW product are the exact product in either representation.
  always_comb begin
    prod_in = '0;
    if (IS_SIGNED) begin
      prod_in = PW'($signed(dataa)) * PW'($signed(datab));
    end else begin
      prod_in = PW'(dataa) * PW'(datab);
    end
  end

  logic [PW-1:0]     prod_q  [PIPELINE];
  logic [WIDTHS-1:0] bias_q  [PIPELINE];
  logic              valid_q [PIPELINE];
  logic              first_q [PIPELINE];
  logic              last_q  [PIPELINE];

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < int'(PIPELINE); i++) begin
        prod_q[i]  <= '0;
        bias_q[i]  <= '0;
        valid_q[i] <= 1'b0;
        first_q[i] <= 1'b0;
        last_q[i]  <= 1'b0;
      end
    end else if (clken) begin
      prod_q[0]  <= prod_in;
      bias_q[0]  <= sum;
      valid_q[0] <= in_valid;
      first_q[0] <= in_first;
      last_q[0]  <= in_last;
      for (int i = 1; i < int'(PIPELINE); i++) begin
        prod_q[i]  <= prod_q[i-1];
        bias_q[i]  <= bias_q[i-1];
        valid_q[i] <= valid_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_prod  = prod_q[PIPELINE-1];
  assign out_bias  = bias_q[PIPELINE-1];
  assign out_valid = valid_q[PIPELINE-1];
  assign out_first = first_q[PIPELINE-1];
  assign out_last  = last_q[PIPELINE-1];

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined multiply-accumulate engine for the CNN datapath.
//  Each window (in_first .. in_last) accumulates dataa*datab onto a bias taken from `sum`
//  on the first beat, and emits one saturated result when the last beat leaves the pipe.
//  Ports:
//   clock, aclr_n, clken : clock, async active-low reset, global clock enable
//   in_valid/first/last  : beat qualifiers; dataa, datab operands; sum bias (first beat only)
//   out_valid            : one enabled-cycle pulse; result/overflow valid with it
//   result               : saturated window sum, held between emits
//   overflow             : accumulator wrapped or result clamped
//   proto_err            : one enabled-cycle pulse on a window protocol violation
//  Constraints: ACC_W >= WIDTHA+WIDTHB, ACC_W >= WIDTHP, ACC_W >= WIDTHS, ACC_W <= 63,
//  PIPELINE in 1..4.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int unsigned WIDTHA         = 8,
  parameter int unsigned WIDTHB         = 8,
  parameter int unsigned WIDTHS         = 16,
  parameter int unsigned WIDTHP         = 16,
  parameter int unsigned ACC_W          = 32,
  parameter int unsigned PIPELINE       = 2,
  parameter string       REPRESENTATION = "SIGNED"
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              clken,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [WIDTHA-1:0] dataa,
  input  logic [WIDTHB-1:0] datab,
  input  logic [WIDTHS-1:0] sum,
  output logic              out_valid,
  output logic [WIDTHP-1:0] result,
  output logic              overflow,
  output logic              proto_err
);

  localparam bit          IsSigned = (REPRESENTATION == "SIGNED") ? REP_SIGNED : REP_UNSIGNED;
  localparam int unsigned PW       = WIDTHA + WIDTHB;

  localparam logic signed [63:0]    MaxLim64 = sat_max(WIDTHP, IsSigned);
  localparam logic signed [63:0]    MinLim64 = sat_min(WIDTHP, IsSigned);
  localparam logic signed [ACC_W:0] MaxLim   = MaxLim64[ACC_W:0];
  localparam logic signed [ACC_W:0] MinLim   = MinLim64[ACC_W:0];

  // Product pipe
  logic              p_valid;
  logic              p_first;
  logic              p_last;
  logic [WIDTHS-1:0] p_bias;
  logic [PW-1:0]     p_prod;

  cnn_mult_pipe #(
    .WIDTHA    (WIDTHA),
    .WIDTHB    (WIDTHB),
    .WIDTHS    (WIDTHS),
    .PIPELINE  (PIPELINE),
    .IS_SIGNED (IsSigned)
  ) u_mult (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .dataa     (dataa),
    .datab     (datab),
    .sum       (sum),
    .out_valid (p_valid),
    .out_first (p_first),
    .out_last  (p_last),
    .out_bias  (p_bias),
    .out_prod  (p_prod)
  );

  // Accumulator state
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // Output registers
  logic              out_valid_q;
  logic [WIDTHP-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;
  logic              emit;

  // Shared adder: a first beat starts from the bias, any other beat from the accumulator.
  logic [ACC_W-1:0] bias_ext;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_lhs;
  logic [ACC_W:0]   add_sum;
  logic             add_wrap;

  always_comb begin
    bias_ext = '0;
    prod_ext = '0;
    if (IsSigned) begin
      bias_ext = ACC_W'($signed(p_bias));
      prod_ext = ACC_W'($signed(p_prod));
    end else begin
      bias_ext = ACC_W'(p_bias);
      prod_ext = ACC_W'(p_prod);
    end
    add_lhs = p_first ? bias_ext : acc_q;
    add_sum = {1'b0, add_lhs} + {1'b0, prod_ext};
    if (IsSigned) begin
      add_wrap = (add_lhs[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (add_sum[ACC_W-1] != add_lhs[ACC_W-1]);
    end else begin
      add_wrap = add_sum[ACC_W];
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // FSM: next state, evaluated on the beat leaving the product pipe
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    emit        = 1'b0;
    proto_err_d = 1'b0;
    if (p_valid) begin
      if (p_first) begin
        // A first beat mid-window discards the partial window and restarts.
        proto_err_d = (state_q == StAccum);
        acc_d       = add_sum[ACC_W-1:0];
        ovf_d       = add_wrap;
        if (p_last) begin
          emit    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StAccum;
        end
      end else if (state_q == StIdle) begin
        // Orphan beat outside a window is dropped.
        proto_err_d = 1'b1;
      end else begin
        acc_d = add_sum[ACC_W-1:0];
        ovf_d = ovf_q | add_wrap;
        if (p_last) begin
          emit    = 1'b1;
          state_d = StIdle;
        end
      end
    end
  end

  // FSM: outputs -- clamp the accumulator to the result range
  logic signed [ACC_W:0] acc_cmp;
  logic                  clamp_hi;
  logic                  clamp_lo;

  always_comb begin
    if (IsSigned) begin
      acc_cmp = {acc_d[ACC_W-1], acc_d};
    end else begin
      acc_cmp = {1'b0, acc_d};
    end
    clamp_hi = (acc_cmp > MaxLim);
    clamp_lo = (acc_cmp < MinLim);
    if (clamp_hi) begin
      result_d = MaxLim[WIDTHP-1:0];
    end else if (clamp_lo) begin
      result_d = MinLim[WIDTHP-1:0];
    end else begin
      result_d = acc_d[WIDTHP-1:0];
    end
    overflow_d = ovf_d | clamp_hi | clamp_lo;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else if (clken) begin
      out_valid_q <= emit;
      proto_err_q <= proto_err_d;
      if (emit) begin
        result_q   <= result_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cnn_mac_pipe.sv
module tb_cnn_mac_pipe;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        clken;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] sum;

  logic        s16_ov, s8_ov, u8_ov;
  logic [15:0] s16_r;
  logic [7:0]  s8_r, u8_r;
  logic        s16_of, s8_of, u8_of;
  logic        s16_pe, s8_pe, u8_pe;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  cnn_mac_pipe #(.WIDTHP(16), .PIPELINE(2), .REPRESENTATION("SIGNED")) u_s16 (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab), .sum(sum),
    .out_valid(s16_ov), .result(s16_r), .overflow(s16_of), .proto_err(s16_pe)
  );

  cnn_mac_pipe #(.WIDTHP(8), .PIPELINE(2), .REPRESENTATION("SIGNED")) u_s8 (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab), .sum(sum),
    .out_valid(s8_ov), .result(s8_r), .overflow(s8_of), .proto_err(s8_pe)
  );

  cnn_mac_pipe #(.WIDTHP(8), .PIPELINE(2), .REPRESENTATION("UNSIGNED")) u_u8 (
    .clock(clock), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab), .sum(sum),
    .out_valid(u8_ov), .result(u8_r), .overflow(u8_of), .proto_err(u8_pe)
  );

  // Emit monitor: a result is consumed at each enabled edge where out_valid is high.
  int cyc = 0;
  int s16_res[$];
  int s16_ovf[$];
  int s16_cyc[$];
  int s8_res[$];
  int s8_ovf[$];
  int u8_res[$];
  int u8_ovf[$];
  int perr_cnt = 0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (clken && s16_ov) begin
      s16_res.push_back(int'($signed(s16_r)));
      s16_ovf.push_back(int'(s16_of));
      s16_cyc.push_back(cyc);
    end
    if (clken && s8_ov) begin
      s8_res.push_back(int'($signed(s8_r)));
      s8_ovf.push_back(int'(s8_of));
    end
    if (clken && u8_ov) begin
      u8_res.push_back(int'(u8_r));
      u8_ovf.push_back(int'(u8_of));
    end
    if (clken && s16_pe) perr_cnt = perr_cnt + 1;
  end

  task automatic clear_mon();
    s16_res.delete(); s16_ovf.delete(); s16_cyc.delete();
    s8_res.delete(); s8_ovf.delete(); u8_res.delete(); u8_ovf.delete();
    perr_cnt = 0;
  endtask

  task automatic beat(input logic f, input logic l, input int a, input int b, input int s);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    dataa    = a[7:0];
    datab    = b[7:0];
    sum      = s[15:0];
    clken    = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic stall(input int n);
    clken = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
    clken = 1'b1;
  endtask

  task automatic test_reset();
    aclr_n = 1'b0; clken = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    dataa = '0; datab = '0; sum = '0;
    #12;
    vectors++;
    if ({s16_ov, s16_r, s16_of, s16_pe} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_s16: got ov=%b r=%0d of=%b pe=%b, want all 0",
               s16_ov, s16_r, s16_of, s16_pe);
    end
    vectors++;
    if ({s8_ov, s8_r, s8_of, s8_pe, u8_ov, u8_r, u8_of, u8_pe} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_8bit: got s8 %b/%0d/%b/%b u8 %b/%0d/%b/%b, want all 0",
               s8_ov, s8_r, s8_of, s8_pe, u8_ov, u8_r, u8_of, u8_pe);
    end
    @(posedge clock); #1;
    aclr_n = 1'b1;
    idle(2);
  endtask

  task automatic test_window_sum();
    int c0;
    clear_mon();
    c0 = cyc;
    // bias 10 + (12 - 10 + 49 + 1) = 62
    beat(1'b1, 1'b0, 3, 4, 10);
    beat(1'b0, 1'b0, -2, 5, 0);
    beat(1'b0, 1'b0, 7, 7, 0);
    beat(1'b0, 1'b1, 1, 1, 0);
    idle(8);
    vectors++;
    if (s16_res.size() != 1) begin
      miscompares++;
      $display("FAIL window_count: got %0d emits, want 1", s16_res.size());
    end else begin
      vectors++;
      if (s16_res[0] != 62 || s16_ovf[0] != 0) begin
        miscompares++;
        $display("FAIL window_result: got %0d ovf %0d, want 62 ovf 0", s16_res[0], s16_ovf[0]);
      end
      vectors++;
      if (s16_cyc[0] != c0 + 7) begin
        miscompares++;
        $display("FAIL window_latency: got edge %0d, want %0d", s16_cyc[0], c0 + 7);
      end
    end
    vectors++;
    if (s8_res.size() != 1 || s8_res[0] != 62 || s8_ovf[0] != 0) begin
      miscompares++;
      $display("FAIL window_s8: got %0d emits first %0d, want 1 emit 62 ovf 0",
               s8_res.size(), (s8_res.size() > 0) ? s8_res[0] : -999);
    end
    vectors++;
    if (s16_ov !== 1'b0 || s16_r !== 16'd62) begin
      miscompares++;
      $display("FAIL window_hold: got ov=%b r=%0d, want ov=0 r=62", s16_ov, s16_r);
    end
  endtask

  task automatic test_single_beat();
    clear_mon();
    beat(1'b1, 1'b1, -128, -128, 0);
    idle(6);
    vectors++;
    if (s16_res.size() != 1 || s16_res[0] != 16384 || s16_ovf[0] != 0) begin
      miscompares++;
      $display("FAIL single_s16: got %0d emits first %0d, want 16384 ovf 0",
               s16_res.size(), (s16_res.size() > 0) ? s16_res[0] : -999);
    end
    vectors++;
    if (s8_res.size() != 1 || s8_res[0] != 127 || s8_ovf[0] != 1) begin
      miscompares++;
      $display("FAIL single_s8: got %0d emits first %0d, want 127 ovf 1",
               s8_res.size(), (s8_res.size() > 0) ? s8_res[0] : -999);
    end
    vectors++;
    if (u8_res.size() != 1 || u8_res[0] != 255 || u8_ovf[0] != 1) begin
      miscompares++;
      $display("FAIL single_u8: got %0d emits first %0d, want 255 ovf 1",
               u8_res.size(), (u8_res.size() > 0) ? u8_res[0] : -999);
    end
  endtask

  task automatic test_unsigned_sat();
    clear_mon();
    beat(1'b1, 1'b0, 255, 255, 0);
    beat(1'b0, 1'b1, 255, 255, 0);
    beat(1'b1, 1'b1, 1, 1, 0);
    idle(6);
    vectors++;
    if (u8_res.size() != 2) begin
      miscompares++;
      $display("FAIL unsigned_count: got %0d emits, want 2", u8_res.size());
    end else begin
      vectors++;
      if (u8_res[0] != 255 || u8_ovf[0] != 1) begin
        miscompares++;
        $display("FAIL unsigned_sat: got %0d ovf %0d, want 255 ovf 1", u8_res[0], u8_ovf[0]);
      end
      vectors++;
      if (u8_res[1] != 1 || u8_ovf[1] != 0) begin
        miscompares++;
        $display("FAIL unsigned_next: got %0d ovf %0d, want 1 ovf 0", u8_res[1], u8_ovf[1]);
      end
    end
  endtask

  task automatic test_back_to_back(input bit do_stall);
    int c0;
    int exp_res[3];
    int exp_cyc[3];
    int d;
    clear_mon();
    d = do_stall ? 3 : 0;
    exp_res = '{27, -26, 111};
    c0 = cyc;
    exp_cyc = '{c0 + 5 + d, c0 + 6 + d, c0 + 9 + d};
    beat(1'b1, 1'b0, 2, 3, 1);
    beat(1'b0, 1'b1, 4, 5, 0);
    beat(1'b1, 1'b1, -3, 7, -5);
    if (do_stall) stall(3);
    beat(1'b1, 1'b0, 10, 10, 0);
    beat(1'b0, 1'b0, 1, 2, 0);
    beat(1'b0, 1'b1, 3, 3, 0);
    idle(8);
    vectors++;
    if (s16_res.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count stall=%0d: got %0d emits, want 3", do_stall, s16_res.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (s16_res[i] != exp_res[i] || s16_ovf[i] != 0 || s16_cyc[i] != exp_cyc[i]) begin
          miscompares++;
          $display("FAIL b2b_win%0d stall=%0d: got %0d ovf %0d @%0d, want %0d ovf 0 @%0d",
                   i, do_stall, s16_res[i], s16_ovf[i], s16_cyc[i], exp_res[i], exp_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_protocol();
    clear_mon();
    beat(1'b0, 1'b0, 9, 9, 0);
    idle(6);
    vectors++;
    if (perr_cnt != 1 || s16_res.size() != 0) begin
      miscompares++;
      $display("FAIL proto_orphan: got perr %0d emits %0d, want perr 1 emits 0",
               perr_cnt, s16_res.size());
    end
    clear_mon();
    beat(1'b1, 1'b0, 2, 2, 100);
    beat(1'b0, 1'b0, 3, 3, 0);
    beat(1'b1, 1'b0, 1, 5, 7);
    beat(1'b0, 1'b1, 2, 2, 0);
    idle(6);
    vectors++;
    if (perr_cnt != 1) begin
      miscompares++;
      $display("FAIL proto_restart_err: got perr %0d, want 1", perr_cnt);
    end
    vectors++;
    if (s16_res.size() != 1 || s16_res[0] != 16 || s16_ovf[0] != 0) begin
      miscompares++;
      $display("FAIL proto_restart_res: got %0d emits first %0d, want 1 emit 16 ovf 0",
               s16_res.size(), (s16_res.size() > 0) ? s16_res[0] : -999);
    end
  endtask

  task automatic test_async_reset();
    beat(1'b1, 1'b0, 5, 5, 50);
    beat(1'b0, 1'b0, 5, 5, 0);
    in_valid = 1'b0;
    in_first = 1'b0;
    #3;
    aclr_n = 1'b0;
    #1;
    vectors++;
    if ({s16_ov, s16_r, s16_of, s16_pe} !== 19'd0) begin
      miscompares++;
      $display("FAIL async_reset: got ov=%b r=%0d of=%b pe=%b, want all 0",
               s16_ov, s16_r, s16_of, s16_pe);
    end
    @(posedge clock); #1;
    aclr_n = 1'b1;
    clear_mon();
    idle(2);
    beat(1'b1, 1'b1, 3, 3, 1);
    idle(6);
    vectors++;
    if (perr_cnt != 0 || s16_res.size() != 1 || s16_res[0] != 10 || s16_ovf[0] != 0) begin
      miscompares++;
      $display("FAIL async_fresh: got perr %0d emits %0d first %0d, want perr 0 one emit 10",
               perr_cnt, s16_res.size(), (s16_res.size() > 0) ? s16_res[0] : -999);
    end
  endtask

  initial begin
    test_reset();
    test_window_sum();
    test_single_beat();
    test_unsigned_sat();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_protocol();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
